// File: rtl/seg_scan_reader_pkg.sv
// Shared definitions for the 7-segment scan reader: segment patterns
// (identical to the display encoder's table) and the dwell-tracking states.
package seg_scan_reader_pkg;

    // Active-high segment patterns, bit order g..a in [6:0].
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h27;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h58;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    // Stability counter width; covers the full STABLE_CYCLES range of 2..255.
    localparam int CNT_W = 8;

    // Per-dwell tracking states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLE   = 2'd1,
        CAPTURED = 2'd2
    } scan_state_e;

endpackage

// File: rtl/seg_scan_reader_seg_to_hex.sv
// Combinational reverse lookup of a 7-segment pattern to its hex digit.
// hit_o is low for any pattern outside the 16-entry table.
module seg_to_hex
    import seg_scan_reader_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] hex_o,
    output logic       hit_o
);

    // Table lookup; unrecognised patterns decode to 0 with hit_o cleared.
    always_comb begin
        hex_o = 4'h0;
        hit_o = 1'b1;
        case (seg_i)
            SEG_0:   hex_o = 4'h0;
            SEG_1:   hex_o = 4'h1;
            SEG_2:   hex_o = 4'h2;
            SEG_3:   hex_o = 4'h3;
            SEG_4:   hex_o = 4'h4;
            SEG_5:   hex_o = 4'h5;
            SEG_6:   hex_o = 4'h6;
            SEG_7:   hex_o = 4'h7;
            SEG_8:   hex_o = 4'h8;
            SEG_9:   hex_o = 4'h9;
            SEG_A:   hex_o = 4'hA;
            SEG_B:   hex_o = 4'hB;
            SEG_C:   hex_o = 4'hC;
            SEG_D:   hex_o = 4'hD;
            SEG_E:   hex_o = 4'hE;
            SEG_F:   hex_o = 4'hF;
            default: hit_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_reader.sv
// Reads back a multiplexed 7-segment display bus. Each digit dwell is
// tracked until its pattern has been stable for STABLE_CYCLES samples, the
// pattern is decoded to hex into a shadow frame, and once every digit has
// been seen the frame is offered on a valid/ready output.
module seg_scan_reader
    import seg_scan_reader_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [7:0]              SEG_IN,
    input  logic [NUM_DIGITS-1:0]   SEL_IN,
    output logic [4*NUM_DIGITS-1:0] DATA_OUT,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic                    ERR,
    output logic                    OVERRUN,
    input  logic                    CLR_FLAGS
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    // Decimal point carries no digit information.
    logic unused_seg_dp;
    assign unused_seg_dp = SEG_IN[7];

    logic [6:0]              seg_q;
    logic [6:0]              seg_prev_q;
    logic [NUM_DIGITS-1:0]   sel_q;
    logic [NUM_DIGITS-1:0]   sel_prev_q;

    scan_state_e             state_q;
    logic [CNT_W-1:0]        cnt_q;

    logic [4*NUM_DIGITS-1:0] shadow_q;
    logic [4*NUM_DIGITS-1:0] shadow_d;
    logic [NUM_DIGITS-1:0]   mask_q;
    logic [NUM_DIGITS-1:0]   mask_d;

    logic [4*NUM_DIGITS-1:0] data_q;
    logic [4*NUM_DIGITS-1:0] data_d;
    logic                    valid_q;
    logic                    valid_d;
    logic                    err_q;
    logic                    err_d;
    logic                    ovr_q;
    logic                    ovr_d;

    logic                    sel_onehot;
    logic                    same_sample;
    logic                    cnt_last;
    logic                    capture;
    logic [3:0]              dec_hex;
    logic                    dec_hit;
    logic                    frame_full;
    logic                    xfer;
    logic                    load;
    logic                    overrun_set;

    // Register the bus every cycle and keep the previous sample for comparison.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            seg_q      <= '0;
            seg_prev_q <= '0;
            sel_q      <= '0;
            sel_prev_q <= '0;
        end else begin
            seg_q      <= SEG_IN[6:0];
            seg_prev_q <= seg_q;
            sel_q      <= SEL_IN;
            sel_prev_q <= sel_q;
        end
    end

    assign sel_onehot  = ($countones(sel_q) == 1);
    assign same_sample = (seg_q == seg_prev_q) && (sel_q == sel_prev_q);
    assign cnt_last    = (cnt_q == CNT_LAST);
    // The sample that completes the stable run is the one being captured.
    assign capture     = sel_onehot && (state_q == SETTLE) && same_sample && cnt_last;

    seg_to_hex u_seg_to_hex (
        .seg_i (seg_q),
        .hex_o (dec_hex),
        .hit_o (dec_hit)
    );

    // Dwell FSM: counts consecutive identical one-hot samples, captures once per dwell.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else if (!sel_onehot) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= SETTLE;
                    cnt_q   <= CNT_W'(1);
                end
                SETTLE: begin
                    if (!same_sample) begin
                        cnt_q <= CNT_W'(1);
                    end else if (cnt_last) begin
                        state_q <= CAPTURED;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                CAPTURED: begin
                    if (!same_sample) begin
                        state_q <= SETTLE;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign frame_full  = (mask_q == {NUM_DIGITS{1'b1}});
    assign xfer        = valid_q && OUT_READY;
    assign load        = frame_full && (!valid_q || OUT_READY);
    assign overrun_set = frame_full && valid_q && !OUT_READY;

    // Shadow frame and seen-mask; the mask empties once a full frame is consumed or dropped.
    always_comb begin
        shadow_d = shadow_q;
        mask_d   = mask_q;
        if (frame_full) begin
            mask_d = '0;
        end
        if (capture && dec_hit) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (sel_q[i]) begin
                    shadow_d[4*i +: 4] = dec_hex;
                    mask_d[i]          = 1'b1;
                end
            end
        end
    end

    // Output register and sticky flags; a set event beats a same-cycle clear.
    always_comb begin
        data_d  = load ? shadow_q : data_q;
        valid_d = load ? 1'b1 : (xfer ? 1'b0 : valid_q);
        err_d   = (CLR_FLAGS ? 1'b0 : err_q) | (capture && !dec_hit);
        ovr_d   = (CLR_FLAGS ? 1'b0 : ovr_q) | overrun_set;
    end

    // State update for frame assembly, output and flags.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            shadow_q <= '0;
            mask_q   <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            mask_q   <= mask_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            ovr_q    <= ovr_d;
        end
    end

    assign DATA_OUT  = data_q;
    assign OUT_VALID = valid_q;
    assign ERR       = err_q;
    assign OVERRUN   = ovr_q;

endmodule
